// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the MEM stage and dmem_responder
//
// Purpose : groups the data-memory request and response channels so the MEM
//           stage (master) and the responder (slave) connect through one port.
// Signals : req_valid_i/req_ready_o   request handshake
//           req_write_i               1 = store, 0 = load
//           req_addr_i                byte address
//           req_wdata_i               store data
//           resp_valid_o/resp_ready_i response handshake
//           resp_rdata_o              load data (0 for stores and errors)
//           resp_err_o                misaligned or out-of-range request
//           busy_o                    responder not idle (to hazard unit)
interface dmem_responder_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_write_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        busy_o;

   modport master (
      output req_valid_i, req_write_i, req_addr_i, req_wdata_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
   );

   modport slave (
      input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, resp_ready_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, busy_o
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with configurable wait states
//
// Purpose : accepts one load/store at a time, waits WAIT_STATES cycles,
//           performs the word access on an internal 2^ADDR_WIDTH x 32 array
//           and holds the response until the MEM stage consumes it.
// Ports   : clk_i  clock, rising edge
//           rst_i  asynchronous active-low reset
//           bus    dmem_responder_if slave modport (request/response/busy)
module dmem_responder #(
   parameter int ADDR_WIDTH  = 7,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   dmem_responder_if.slave   bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);
   localparam bit         NO_WAIT  = (WAIT_STATES == 0);

   logic [1:0]            state;
   logic [3:0]            cnt;
   logic                  wr_q;
   logic [31:0]           addr_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;
   logic                  err_q;

   logic [31:0]           mem [0:DEPTH-1];

   logic                  access;
   logic                  acc_write;
   logic [31:0]           acc_addr;
   logic [31:0]           acc_wdata;
   logic                  acc_err;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic [31:0]           acc_rdata;

   // With no wait states the access happens on the accept edge itself, so it
   // must use the live request; otherwise it uses the transaction latched at
   // accept, which makes later req_* changes irrelevant.
   always_comb begin
      if (NO_WAIT) begin
         access    = (state == S_IDLE) && bus.req_valid_i;
         acc_write = bus.req_write_i;
         acc_addr  = bus.req_addr_i;
         acc_wdata = bus.req_wdata_i;
      end else begin
         access    = (state == S_WAIT) && (cnt == 4'd1);
         acc_write = wr_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
      end
      acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
      acc_idx   = acc_addr[ADDR_WIDTH+1:2];
      acc_rdata = (acc_write || acc_err) ? 32'd0 : mem[acc_idx];
   end

   // Handshake outputs come from state only; response data from registers.
   assign bus.req_ready_o  = (state == S_IDLE);
   assign bus.resp_valid_o = (state == S_RESP);
   assign bus.busy_o       = (state != S_IDLE);
   assign bus.resp_rdata_o = rdata_q;
   assign bus.resp_err_o   = err_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         wr_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (access) begin
            rdata_q <= acc_rdata;
            err_q   <= acc_err;
         end
         case (state)
            S_IDLE: begin
               if (bus.req_valid_i) begin
                  wr_q    <= bus.req_write_i;
                  addr_q  <= bus.req_addr_i;
                  wdata_q <= bus.req_wdata_i;
                  cnt     <= WAIT_CNT;
                  state   <= NO_WAIT ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd1) begin
                  state <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               // Response registers return to 0 once consumed so an idle
               // port presents the same values as after reset.
               if (bus.resp_ready_i) begin
                  state   <= S_IDLE;
                  rdata_q <= 32'd0;
                  err_q   <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // The array is never cleared, but no write may land while reset is held:
   // with no wait states a request presented during reset would otherwise
   // commit on a clock edge even though the state machine is pinned in IDLE.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
      end else if (access && acc_write && !acc_err) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder_if b2 ();
   dmem_responder_if b0 ();

   dmem_responder #(.ADDR_WIDTH(7), .WAIT_STATES(2)) dut2 (.clk_i(clk), .rst_i(rst_n), .bus(b2));
   dmem_responder #(.ADDR_WIDTH(7), .WAIT_STATES(0)) dut0 (.clk_i(clk), .rst_i(rst_n), .bus(b0));

   // sel = 0 drives the 2-wait-state instance, sel = 1 the zero-wait instance
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic        resp_ready = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;

   assign b2.req_valid_i  = req_valid & ~sel;
   assign b0.req_valid_i  = req_valid & sel;
   assign b2.resp_ready_i = resp_ready & ~sel;
   assign b0.resp_ready_i = resp_ready & sel;
   assign b2.req_write_i  = req_write;
   assign b0.req_write_i  = req_write;
   assign b2.req_addr_i   = req_addr;
   assign b0.req_addr_i   = req_addr;
   assign b2.req_wdata_i  = req_wdata;
   assign b0.req_wdata_i  = req_wdata;

   wire        r_ready = sel ? b0.req_ready_o  : b2.req_ready_o;
   wire        r_valid = sel ? b0.resp_valid_o : b2.resp_valid_o;
   wire [31:0] r_rdata = sel ? b0.resp_rdata_o : b2.resp_rdata_o;
   wire        r_err   = sel ? b0.resp_err_o   : b2.resp_err_o;
   wire        r_busy  = sel ? b0.busy_o       : b2.busy_o;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          last_acc = 0;
   int          cur_acc  = 0;
   logic [31:0] rd;
   logic        er;
   int          lat;

   // One complete transaction; lat = edges from accept edge to resp_valid.
   // scramble alters every req_* input while the request is in flight.
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input bit scramble, output logic [31:0] rdo, output logic ero,
                      output int lato);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      tick();
      last_acc  = cur_acc;
      cur_acc   = cyc;
      req_valid = 1'b0;
      if (scramble) begin
         req_write = ~w;
         req_addr  = 32'h0000_0010;
         req_wdata = 32'hFFFF_FFFF;
      end
      lato = 0;
      while (!r_valid && lato < 20) begin
         tick();
         lato++;
      end
      rdo = r_rdata;
      ero = r_err;
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
   endtask

   initial begin
      // ---------------- reset state
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 32'(r_ready), 32'd1);
      chk("rst_valid", 32'(r_valid), 32'd0);
      chk("rst_busy",  32'(r_busy),  32'd0);
      chk("rst_rdata", r_rdata,      32'd0);
      chk("rst_err",   32'(r_err),   32'd0);

      // ---------------- reset mid-WAIT: interrupted store never commits
      txn(1'b1, 32'h10, 32'h0, 1'b0, rd, er, lat);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
      tick();
      req_valid = 1'b0;
      chk("mw_busy_wait", 32'(r_busy), 32'd1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("mw_busy_rst",  32'(r_busy),  32'd0);
      chk("mw_valid_rst", 32'(r_valid), 32'd0);
      chk("mw_ready_rst", 32'(r_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();
      txn(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      chk("mw_load", rd, 32'h0000_0000);

      // ---------------- back-to-back store/load
      txn(1'b1, 32'h04, 32'h1234_5678, 1'b0, rd, er, lat);
      chk("bb_st_lat",   32'(lat), 32'd2);
      chk("bb_st_rdata", rd,       32'd0);
      chk("bb_st_err",   32'(er),  32'd0);
      txn(1'b0, 32'h04, 32'h0, 1'b0, rd, er, lat);
      chk("bb_spacing",  32'(cur_acc - last_acc), 32'd4);
      chk("bb_ld_rdata", rd,       32'h1234_5678);
      chk("bb_ld_err",   32'(er),  32'd0);

      // ---------------- back-pressure with a queued request behind it
      txn(1'b1, 32'h08, 32'h0BAD_F00D, 1'b0, rd, er, lat);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h04;
      chk("bp_ready_idle", 32'(r_ready), 32'd1);
      tick();
      req_addr = 32'h08;
      lat = 0;
      while (!r_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rdata", r_rdata,         32'h1234_5678);
         chk("bp_valid", 32'(r_valid),    32'd1);
         chk("bp_ready", 32'(r_ready),    32'd0);
         tick();
      end
      chk("bp_rdata_last", r_rdata, 32'h1234_5678);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("bp_idle_ready", 32'(r_ready), 32'd1);
      chk("bp_idle_valid", 32'(r_valid), 32'd0);
      tick();
      req_valid = 1'b0;
      chk("bp_next_busy", 32'(r_busy), 32'd1);
      lat = 0;
      while (!r_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("bp_next_rdata", r_rdata, 32'h0BAD_F00D);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;

      // ---------------- error cases
      txn(1'b1, 32'h00, 32'h1111_1111, 1'b0, rd, er, lat);
      txn(1'b1, 32'h06, 32'hAAAA_5555, 1'b0, rd, er, lat);
      chk("err_mis_err",   32'(er), 32'd1);
      chk("err_mis_rdata", rd,      32'd0);
      txn(1'b1, 32'h200, 32'hAAAA_5555, 1'b0, rd, er, lat);
      chk("err_oor_err",   32'(er), 32'd1);
      chk("err_oor_rdata", rd,      32'd0);
      txn(1'b0, 32'h00, 32'h0, 1'b0, rd, er, lat);
      chk("err_w0",     rd,      32'h1111_1111);
      chk("err_w0_err", 32'(er), 32'd0);
      txn(1'b0, 32'h04, 32'h0, 1'b0, rd, er, lat);
      chk("err_w1", rd, 32'h1234_5678);
      txn(1'b0, 32'h200, 32'h0, 1'b0, rd, er, lat);
      chk("err_ld_oor_err",   32'(er), 32'd1);
      chk("err_ld_oor_rdata", rd,      32'd0);

      // ---------------- input hold: req_* change while in WAIT
      txn(1'b1, 32'h0C, 32'h55AA_55AA, 1'b1, rd, er, lat);
      chk("hold_st_rdata", rd,      32'd0);
      chk("hold_st_err",   32'(er), 32'd0);
      txn(1'b0, 32'h0C, 32'h0, 1'b1, rd, er, lat);
      chk("hold_ld_0c", rd, 32'h55AA_55AA);
      txn(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      chk("hold_ld_10", rd, 32'h0000_0000);

      // ---------------- zero-wait-state instance, last word
      sel = 1'b1;
      #1;
      chk("ws0_ready", 32'(r_ready), 32'd1);
      txn(1'b1, 32'h1FC, 32'hCAFE_F00D, 1'b0, rd, er, lat);
      chk("ws0_st_lat", 32'(lat), 32'd0);
      chk("ws0_st_err", 32'(er),  32'd0);
      txn(1'b0, 32'h1FC, 32'h0, 1'b0, rd, er, lat);
      chk("ws0_ld_lat",   32'(lat), 32'd0);
      chk("ws0_ld_rdata", rd,       32'hCAFE_F00D);
      chk("ws0_spacing",  32'(cur_acc - last_acc), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time from the MEM stage over a valid/ready handshake. It inserts a configurable number of wait states, performs the word access on an internal array, and returns read data or a store acknowledgement over a valid/ready response channel. The MEM stage stalls while its request or response is outstanding; `busy_o` drives the hazard unit.

## Interface
- `ADDR_WIDTH`, 7: word-index width; array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_STATES`, 2: cycles spent in WAIT between accept and access; legal range 0..15.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: MEM stage presents a request.
- `req_ready_o` out 1: responder can accept a request.
- `req_write_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data.
- `resp_valid_o` out 1: response available.
- `resp_ready_i` in 1: MEM stage consumes the response.
- `resp_rdata_o` out 32: load data; 0 for stores and errors.
- `resp_err_o` out 1: request was misaligned or out of range.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- States are IDLE, WAIT and RESP.
- **IDLE:** `req_ready_o`=1.
  - Accept happens on an edge with `req_valid_i`=1.
  - On accept, latch write, addr and wdata.
  - Load cnt=WAIT_STATES and go to WAIT.
  - If WAIT_STATES=0, perform the access on the accept edge and go directly to RESP.
- **WAIT:** `req_ready_o`=0.
  - Each edge: if cnt==1, perform the access and go to RESP; else cnt<=cnt-1.
  - A 4-bit cnt is sufficient.
- **RESP:** `resp_valid_o`=1.
  - `resp_rdata_o` and `resp_err_o` are held stable until an edge with `resp_ready_i`=1; then go to IDLE.
  - No new request is accepted in RESP; the earliest next accept is the cycle after returning to IDLE.
- **Access:**
  - err = (addr[1:0]!=0) or (addr[31:ADDR_WIDTH+2]!=0).
  - Word index = addr[ADDR_WIDTH+1:2].
  - Store with err=0: array[idx]<=wdata; rdata register<=0.
  - Load with err=0: rdata register<=array[idx].
  - err=1: no array write; rdata register<=0; err register<=1.
- Request inputs are ignored outside IDLE. Changes on `req_*` during WAIT or RESP must not affect the latched transaction.
- **Reset:**
  - State<=IDLE and cnt<=0.
  - `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0, `busy_o`=0, `req_ready_o`=1.
  - The array is not cleared.
  - A store interrupted by reset before its access edge is never committed. A store whose access edge has already occurred stays committed.

## Timing
- Accept edge E0; access at edge E0+WAIT_STATES; `resp_valid_o` high from the cycle after that edge.
  - WAIT_STATES=2: accept at edge 0, access at edge 2, valid in cycle 3.
- Minimum request-to-request spacing is WAIT_STATES+2 cycles (accept, WAIT_STATES, one RESP cycle with `resp_ready_i`=1, IDLE).
- Response back-pressure: RESP may last any number of cycles. Outputs must not glitch or change while `resp_valid_o`=1.
- `req_ready_o`, `resp_valid_o` and `busy_o` are decoded from registered state only, with no combinational path from inputs.
- Load-after-store to the same address returns the stored value, because the store committed before its response.

## Test plan
- **Reset mid-WAIT:**
  - Stimulus: store 0xDEADBEEF to addr 0x10 and assert `rst_i`=0 one cycle after accept; release reset, then load 0x10.
  - Required: the store is not committed. The load returns the pre-existing word (write 0x0 to 0x10 first, so expect 0x00000000). After reset, `busy_o`=0 and `resp_valid_o`=0.
- **Back-to-back store/load, WAIT_STATES=2:**
  - Stimulus: store 0x12345678 to 0x04, then load 0x04 with `resp_ready_i` held high.
  - Required: first `resp_valid_o` 3 cycles after accept, rdata=0, err=0. Second accept occurs 4 cycles after the first. The load returns 0x12345678.
- **Back-pressure:**
  - Stimulus: load 0x04 with `resp_ready_i`=0 for 5 cycles, then 1; keep `req_valid_i`=1 with addr 0x08 throughout.
  - Required: `resp_rdata_o`=0x12345678 stable for all RESP cycles. `req_ready_o`=0 until IDLE, then addr 0x08 is accepted.
- **Error cases:**
  - Stimulus: store 0xAAAA5555 to 0x06 (misaligned); then store to 0x200 (out of range for ADDR_WIDTH=7); then load 0x00.
  - Required: both stores give `resp_err_o`=1 and rdata=0. Neither modifies the array; word 0 (index 0x200>>2 would alias) keeps its prior value.
- **WAIT_STATES=0 build:**
  - Stimulus: load after store of 0xCAFEF00D to 0x1FC.
  - Required: `resp_valid_o` is high the cycle after accept. The load returns 0xCAFEF00D (last word, index 127).
- **Input hold check:**
  - Stimulus: during WAIT, change `req_addr_i`, `req_wdata_i` and `req_write_i`.
  - Required: the response reflects the values latched at accept only.
